cfg_descriptor_tx: RTL



---
 rtl/cfg_descriptor_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cfg_descriptor_tx.sv
// Streams an 8-word checksummed descriptor of the elaborated core configuration over valid/ready.
// First word is visible the cycle after start; each word holds until ready_i, and done_o follows W7 by one cycle.

package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned VLEN;
      int unsigned PLEN;
      int unsigned GPLEN;
      bit          RVA;
      bit          RVB;
      bit          RVC;
      bit          RVD;
      bit          RVF;
      bit          RVH;
      bit          RVS;
      bit          RVU;
      bit          RVV;
      bit          RVZCB;
      bit          RVZCMP;
      bit          RVZCMT;
      bit          RVZiCond;
      bit          RVZicntr;
      bit          RVZihpm;
      bit          ZKN;
      bit          XF16;
      bit          XF16ALT;
      bit          XF8;
      bit          XFVec;
      bit          CvxifEn;
      bit          MmuPresent;
      bit          DebugEn;
      bit          SDTRIG;
      bit          SuperscalarEn;
      bit          PerfCounterEn;
      int unsigned NR_SB_ENTRIES;
      int unsigned NrCommitPorts;
      int unsigned NrIssuePorts;
      int unsigned NrWbPorts;
      int unsigned NrRgprPorts;
      int unsigned NrPMPEntries;
      int unsigned ICACHE_SET_ASSOC;
      int unsigned ICACHE_INDEX_WIDTH;
      int unsigned ICACHE_LINE_WIDTH;
      int unsigned DCACHE_SET_ASSOC;
      int unsigned DCACHE_INDEX_WIDTH;
      int unsigned DCACHE_LINE_WIDTH;
      int unsigned InstrTlbEntries;
      int unsigned DataTlbEntries;
      int unsigned FLen;
      int unsigned RASDepth;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

module cfg_descriptor_tx #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        abort_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] data_o,
   output logic        last_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   // The whole descriptor, checksum included, is folded to constants here.
   function automatic logic [7:0][31:0] build_words(input config_pkg::cva6_cfg_t c);
      logic [7:0][31:0] w;
      logic [31:0]      sum;
      w    = '0;
      w[0] = 32'hC7A6_0001;
      w[1] = {8'(c.GPLEN), 8'(c.PLEN), 8'(c.VLEN), 8'(c.XLEN)};
      w[2] = {6'd0, c.PerfCounterEn, c.SuperscalarEn, c.SDTRIG, c.DebugEn,
              c.MmuPresent, c.CvxifEn, c.XFVec, c.XF8, c.XF16ALT, c.XF16,
              c.ZKN, c.RVZihpm, c.RVZicntr, c.RVZiCond, c.RVZCMT, c.RVZCMP,
              c.RVZCB, c.RVV, c.RVU, c.RVS, c.RVH, c.RVF, c.RVD, c.RVC,
              c.RVB, c.RVA};
      w[3] = {8'(c.NrPMPEntries), 4'(c.NrRgprPorts), 4'(c.NrWbPorts),
              4'(c.NrIssuePorts), 4'(c.NrCommitPorts), 8'(c.NR_SB_ENTRIES)};
      w[4] = {16'(c.ICACHE_LINE_WIDTH), 8'(c.ICACHE_INDEX_WIDTH), 8'(c.ICACHE_SET_ASSOC)};
      w[5] = {16'(c.DCACHE_LINE_WIDTH), 8'(c.DCACHE_INDEX_WIDTH), 8'(c.DCACHE_SET_ASSOC)};
      w[6] = {8'(c.RASDepth), 8'(c.FLen), 8'(c.DataTlbEntries), 8'(c.InstrTlbEntries)};
      sum  = '0;
      for (int i = 0; i < 7; i++) begin
         sum = sum + w[i];
      end
      w[7] = 32'd0 - sum;
      return w;
   endfunction

   localparam logic [7:0][31:0] WORDS = build_words(CVA6Cfg);

   logic [0:0] state;
   logic [2:0] idx;
   logic       done_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= IDLE;
         idx    <= 3'd0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state <= SEND;
                  idx   <= 3'd0;
               end
            end
            default: begin
               if (abort_i) begin
                  state <= IDLE;
                  idx   <= 3'd0;
               end else if (ready_i) begin
                  if (idx == 3'd7) begin
                     state  <= IDLE;
                     idx    <= 3'd0;
                     done_q <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
         endcase
      end
   end

   // Outputs decode only registered state, so reset clears them without a clock.
   assign valid_o = (state == SEND);
   assign busy_o  = (state == SEND);
   assign data_o  = (state == SEND) ? WORDS[idx] : 32'd0;
   assign last_o  = (state == SEND) && (idx == 3'd7);
   assign done_o  = done_q;

endmodule
